// File: rtl/sensor_pkg.sv
// Shared scheduler types and simulation-sized timing defaults for the ultrasonic
// measurement scheduler.
package sensor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRE,
    ST_WAIT,
    ST_STORE,
    ST_GAP
  } state_t;

  localparam int SIM_GAP_CYC    = 20;
  localparam int SIM_PERIOD_CYC = 500;
  localparam int SIM_WD_CYC     = 200;

  // Result word reported when the engine never answers.
  localparam logic [31:0] WD_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/meas_sched_rr_pick.sv
// Round-robin picker: first pending channel strictly after `last`, wrapping to 0.
module rr_pick #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] pending,
  input  logic [CH_W-1:0] last,
  output logic [CH_W-1:0] grant,
  output logic            any
);

  // Walk from farthest to nearest so the nearest pending channel is written last.
  always_comb begin
    int idx;
    grant = last;
    for (int i = N_CH; i >= 1; i--) begin
      idx = (int'(last) + i) % N_CH;
      if (pending[idx]) grant = CH_W'(idx);
    end
  end

  assign any = |pending;

endmodule

// File: rtl/meas_sched.sv
// Shares one ultrasonic measurement engine among N_CH sensors: host/auto requests
// pend per channel, a round-robin grant fires the engine, results are reported once.
module meas_sched
  import sensor_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int GAP_CYC    = 3_000_000,
  parameter int PERIOD_CYC = 10_000_000,
  parameter int WD_CYC     = 50_000_000
) (
  input  logic                     clk_sys,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          req,
  input  logic                     auto_en,
  output logic                     fire_measure,
  input  logic                     done_measure,
  input  logic                     err_measure,
  input  logic [31:0]              data_measure,
  input  logic                     trig_core,
  output logic                     echo_core,
  output logic [N_CH-1:0]          trig_out,
  input  logic [N_CH-1:0]          echo_in,
  output logic                     res_valid,
  output logic [$clog2(N_CH)-1:0]  res_ch,
  output logic [31:0]              res_data,
  output logic                     res_err,
  output logic                     busy
);

  localparam int CH_W = $clog2(N_CH);

  state_t            state;
  logic [N_CH-1:0]   pend;
  logic [N_CH-1:0]   clr;
  logic [CH_W-1:0]   sel;
  logic [CH_W-1:0]   last;
  logic [CH_W-1:0]   grant;
  logic              any;
  logic              tick;
  logic              route;
  logic [31:0]       tmr;
  logic [31:0]       cnt;

  rr_pick #(.N_CH(N_CH), .CH_W(CH_W)) u_pick (
    .pending (pend),
    .last    (last),
    .grant   (grant),
    .any     (any)
  );

  assign tick  = auto_en && (tmr == 32'(PERIOD_CYC - 1));
  assign route = (state == ST_FIRE) || (state == ST_WAIT);
  assign busy  = (state != ST_IDLE);

  always_comb begin
    clr = '0;
    if (state == ST_IDLE && any) clr[grant] = 1'b1;
  end

  // Sets are OR-ed in after the clear so a request landing on its own grant survives.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= (pend & ~clr) | req | {N_CH{tick}};
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)       tmr <= '0;
    else if (!auto_en || tick) tmr <= '0;
    else              tmr <= tmr + 32'd1;
  end

  // cnt is shared: watchdog in WAIT, guard time in GAP.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      sel          <= '0;
      last         <= CH_W'(N_CH - 1);
      cnt          <= '0;
      fire_measure <= 1'b0;
      res_valid    <= 1'b0;
      res_ch       <= '0;
      res_data     <= '0;
      res_err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (any) begin
          sel          <= grant;
          last         <= grant;
          fire_measure <= 1'b1;
          state        <= ST_FIRE;
        end
        ST_FIRE: begin
          fire_measure <= 1'b0;
          cnt          <= '0;
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_measure) begin
            res_valid <= 1'b1;
            res_ch    <= sel;
            res_data  <= data_measure;
            res_err   <= err_measure;
            state     <= ST_STORE;
          end else if (cnt == 32'(WD_CYC - 1)) begin
            res_valid <= 1'b1;
            res_ch    <= sel;
            res_data  <= WD_DATA;
            res_err   <= 1'b1;
            state     <= ST_STORE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_STORE: begin
          res_valid <= 1'b0;
          cnt       <= '0;
          state     <= ST_GAP;
        end
        ST_GAP: begin
          if (cnt == 32'(GAP_CYC - 1)) state <= ST_IDLE;
          else                         cnt   <= cnt + 32'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign echo_core = route ? echo_in[sel] : 1'b0;

  always_comb begin
    trig_out = '0;
    if (route) trig_out[sel] = trig_core;
  end

endmodule

// File: tb/tb_meas_sched.sv
// Randomized scoreboard bench for meas_sched: a timestamped transaction model predicts
// every fire and result; a monitor compares them against what the DUT presents.
module tb_meas_sched;
  import sensor_pkg::*;

  localparam int NC  = 4;
  localparam int GAP = SIM_GAP_CYC;
  localparam int PER = SIM_PERIOD_CYC;
  localparam int WD  = SIM_WD_CYC;

  logic          clk_sys = 1'b0;
  logic          rst_n = 1'b0;
  logic [NC-1:0] req = '0;
  logic          auto_en = 1'b0;
  logic          fire_measure;
  logic          done_measure = 1'b0;
  logic          err_measure = 1'b0;
  logic [31:0]   data_measure = '0;
  logic          trig_core = 1'b0;
  logic          echo_core;
  logic [NC-1:0] trig_out;
  logic [NC-1:0] echo_in = '0;
  logic          res_valid;
  logic [1:0]    res_ch;
  logic [31:0]   res_data;
  logic          res_err;
  logic          busy;

  always #5 clk_sys = ~clk_sys;

  meas_sched #(.N_CH(NC), .GAP_CYC(GAP), .PERIOD_CYC(PER), .WD_CYC(WD)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .req(req), .auto_en(auto_en),
    .fire_measure(fire_measure), .done_measure(done_measure), .err_measure(err_measure),
    .data_measure(data_measure), .trig_core(trig_core), .echo_core(echo_core),
    .trig_out(trig_out), .echo_in(echo_in), .res_valid(res_valid), .res_ch(res_ch),
    .res_data(res_data), .res_err(res_err), .busy(busy)
  );

  typedef struct {int ch; int g;} fire_t;
  typedef struct {int ch; int w; logic [31:0] data; logic err;} res_t;
  typedef struct {bit timeout; int d; logic [31:0] data; logic err;} plan_t;
  typedef struct {bit has_done; int w; logic [31:0] data; logic err;} act_t;

  fire_t exp_fire[$];
  res_t  exp_res[$];
  plan_t forced[$];
  act_t  bfm_q[$];
  int    seen_ch[$];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  // Model state: pending set, last grant, edge at which the engine is next free.
  logic [NC-1:0] mpend = '0;
  int  mlast = NC - 1;
  int  free_at = 0;
  int  auto_since = 0;
  bit  auto_on = 0;
  bit  cur_valid = 0;
  int  cur_ch = 0, cur_g = 0, cur_w = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Edge-numbered model: engine free after STORE edge w + GAP guard + return to IDLE.
  always @(posedge clk_sys) begin
    plan_t p;
    res_t  r;
    int    ch;
    cyc++;
    if (!rst_n) begin
      mpend = '0; mlast = NC - 1; free_at = 0; auto_on = 0; cur_valid = 0;
      exp_fire.delete(); exp_res.delete(); bfm_q.delete();
    end else begin
      if (cyc >= free_at && mpend != '0) begin
        ch = -1;
        for (int i = 1; i <= NC; i++)
          if (ch < 0 && mpend[(mlast + i) % NC]) ch = (mlast + i) % NC;
        if (forced.size() > 0) p = forced.pop_front();
        else begin
          p.timeout = ($urandom_range(0, 9) == 0);
          p.d       = ($urandom_range(0, 7) == 0) ? WD : $urandom_range(1, 30);
          p.data    = $urandom;
          p.err     = ($urandom_range(0, 4) == 0);
        end
        r.ch = ch;
        if (p.timeout) begin r.w = cyc + 1 + WD; r.data = 32'hFFFF_FFFF; r.err = 1'b1; end
        else begin r.w = cyc + 1 + p.d; r.data = p.data; r.err = p.err; end
        exp_fire.push_back(fire_t'{ch, cyc});
        exp_res.push_back(r);
        bfm_q.push_back(act_t'{!p.timeout, r.w, p.data, p.err});
        mpend[ch] = 1'b0;
        mlast = ch;
        free_at = r.w + GAP + 2;
        cur_valid = 1; cur_ch = ch; cur_g = cyc; cur_w = r.w;
      end
      mpend |= req;
      if (auto_en) begin
        if (!auto_on) begin auto_on = 1; auto_since = cyc; end
        if (((cyc - auto_since) % PER) == PER - 1) mpend = '1;
      end else auto_on = 0;
    end
  end

  // Engine BFM: answers each fire per its plan, plus a stray done during the guard time.
  act_t act;
  bit   act_v = 0;
  always @(negedge clk_sys) begin
    done_measure = 1'b0;
    err_measure  = 1'b0;
    data_measure = $urandom;
    if (!rst_n) act_v = 0;
    else begin
      if (fire_measure && bfm_q.size() > 0) begin act = bfm_q.pop_front(); act_v = 1; end
      if (act_v && act.has_done && cyc == act.w - 1) begin
        done_measure = 1'b1; data_measure = act.data; err_measure = act.err;
      end else if (act_v && act.has_done && cyc == act.w + 2) begin
        done_measure = 1'b1; err_measure = 1'b1; act_v = 0;
      end
    end
  end

  always @(posedge clk_sys) begin
    #2;
    trig_core = 1'($urandom);
    echo_in   = NC'($urandom);
  end

  // Monitor
  logic [1:0]  hold_ch = '0;
  logic [31:0] hold_data = '0;
  logic        hold_err = 1'b0;
  int          last_w = -1000;
  always @(negedge clk_sys) begin
    bit            route, ebusy, eecho;
    logic [NC-1:0] etrig;
    fire_t         f;
    res_t          r;
    if (!rst_n) begin
      hold_ch = '0; hold_data = '0; hold_err = 1'b0; last_w = -1000;
    end else begin
      route = cur_valid && cyc >= cur_g && cyc < cur_w;
      ebusy = cur_valid && cyc >= cur_g && cyc <= cur_w + GAP;
      etrig = (route && trig_core) ? NC'(1 << cur_ch) : '0;
      eecho = route ? echo_in[cur_ch] : 1'b0;
      chk("pins", {trig_out, echo_core, busy}, {etrig, eecho, ebusy});
      if (fire_measure) begin
        if (exp_fire.size() == 0) chk("fire_unexpected", exp_fire.size(), 1);
        else begin
          f = exp_fire.pop_front();
          chk("fire_cycle", cyc, f.g);
          chk("fire_gap_ok", (cyc - last_w - 1) >= GAP, 1);
        end
      end else if (exp_fire.size() > 0 && exp_fire[0].g < cyc) begin
        chk("fire_missing", fire_measure, 1);
        void'(exp_fire.pop_front());
      end
      if (res_valid) begin
        if (exp_res.size() == 0) chk("res_unexpected", exp_res.size(), 1);
        else begin
          r = exp_res.pop_front();
          chk("res_cycle", cyc, r.w);
          chk("res_ch", res_ch, r.ch);
          chk("res_data", res_data, r.data);
          chk("res_err", res_err, r.err);
          hold_ch = 2'(r.ch); hold_data = r.data; hold_err = r.err;
          seen_ch.push_back(r.ch);
          last_w = cyc;
        end
      end else begin
        if (exp_res.size() > 0 && exp_res[0].w < cyc) begin
          chk("res_missing", res_valid, 1);
          void'(exp_res.pop_front());
        end
        chk("res_hold", {res_ch, res_data, res_err}, {hold_ch, hold_data, hold_err});
      end
    end
  end

  task automatic pulse_req(input logic [NC-1:0] v);
    @(negedge clk_sys); req = v;
    @(negedge clk_sys); req = '0;
  endtask

  task automatic wait_idle(input int maxc);
    int k = 0;
    repeat (3) @(negedge clk_sys);
    while ((busy || exp_res.size() > 0 || mpend != '0) && k < maxc) begin
      @(negedge clk_sys); k++;
    end
    chk("idle_reached", k < maxc, 1);
  endtask

  task automatic chk_outs_zero(input string name);
    chk(name, {fire_measure, trig_out, echo_core, res_valid, res_ch, res_data, res_err, busy}, '0);
  endtask

  initial begin
    int  e, k, c0, c1, c3;
    bit  did;
    // Reset state
    repeat (2) @(negedge clk_sys);
    chk_outs_zero("reset_outs");
    rst_n = 1'b1;
    repeat (3) @(negedge clk_sys);

    // Single request on ch2, data 1234
    forced.push_back(plan_t'{1'b0, 5, 32'd1234, 1'b0});
    @(negedge clk_sys); req = 4'b0100; e = cyc + 1;
    @(negedge clk_sys); req = '0;
    k = 0;
    while (!fire_measure && k < 10) begin @(negedge clk_sys); k++; end
    chk("req_to_fire", cyc - (e - 1), 2);
    @(negedge clk_sys);
    chk("trig2_follows", {trig_out[2], trig_out[1:0], trig_out[3]}, {trig_core, 3'b000});
    wait_idle(200);

    // Engine error flag with data
    forced.push_back(plan_t'{1'b0, 3, 32'd9, 1'b1});
    pulse_req(4'b0010);
    wait_idle(200);

    // Watchdog expiry
    forced.push_back(plan_t'{1'b1, 0, 32'd0, 1'b0});
    pulse_req(4'b0100);
    wait_idle(WD + 100);

    // All four at once after reset: order 0,1,2,3
    @(negedge clk_sys); rst_n = 1'b0;
    repeat (3) @(negedge clk_sys); rst_n = 1'b1;
    seen_ch.delete();
    pulse_req(4'b1111);
    wait_idle(2000);
    chk("order_len", seen_ch.size(), 4);
    for (int i = 0; i < seen_ch.size() && i < 4; i++) chk("order", seen_ch[i], i);

    // Auto scan with a re-request of ch1 while ch1 waits on the engine
    seen_ch.delete();
    for (int i = 0; i < 13; i++) forced.push_back(plan_t'{1'b0, 5, 32'($urandom), 1'b0});
    did = 0;
    @(negedge clk_sys); auto_en = 1'b1;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk_sys); req = '0;
      if (!did && cur_valid && cur_ch == 1 && cyc >= cur_g + 1 && cyc <= cur_w - 2) begin
        req = 4'b0010; did = 1;
      end
    end
    req = '0; auto_en = 1'b0;
    wait_idle(1000);
    c0 = 0; c1 = 0; c3 = 0;
    foreach (seen_ch[i]) begin
      if (seen_ch[i] == 0) c0++;
      if (seen_ch[i] == 1) c1++;
      if (seen_ch[i] == 3) c3++;
    end
    chk("auto_ch0", c0, 3);
    chk("auto_ch1_rereq", c1, 4);
    chk("auto_ch3", c3, 3);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_sys);
      req = ($urandom_range(0, 7) == 0) ? NC'($urandom) : '0;
    end
    req = '0;
    wait_idle(3000);

    // Reset while ch3 waits on the engine
    forced.push_back(plan_t'{1'b1, 0, 32'd0, 1'b0});
    pulse_req(4'b1000);
    repeat (15) @(negedge clk_sys);
    chk("pre_rst_ch3", {cur_ch, busy}, {32'd3, 1'b1});
    @(negedge clk_sys); rst_n = 1'b0;
    #1 chk_outs_zero("midrun_reset_outs");
    repeat (3) @(negedge clk_sys);
    chk_outs_zero("held_reset_outs");
    rst_n = 1'b1;
    repeat (30) @(negedge clk_sys);
    chk("no_refire_after_rst", busy, 0);
    seen_ch.delete();
    pulse_req(4'b1001);
    wait_idle(1000);
    chk("post_rst_len", seen_ch.size(), 2);
    if (seen_ch.size() >= 2) begin
      chk("post_rst_first", seen_ch[0], 0);
      chk("post_rst_second", seen_ch[1], 3);
    end

    chk("drain_fire_q", exp_fire.size(), 0);
    chk("drain_res_q", exp_res.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL global_timeout: cycle %0d reached without finishing", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/meas_sched.md
MEAS_SCHED -- requirements
Module: meas_sched

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of ultrasonic channels sharing one measurement engine.
REQ-002 SHALL have parameter GAP_CYC, default 3_000_000: guard cycles between measurements (echo ring-down).
REQ-003 SHALL have parameter PERIOD_CYC, default 10_000_000: auto-scan period in clk_sys cycles.
REQ-004 SHALL have parameter WD_CYC, default 50_000_000: watchdog limit while waiting for engine done.
REQ-005 SHALL have port clk_sys, input, 1: system clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port req, input, N_CH: per-channel one-cycle measurement request from host.
REQ-008 SHALL have port auto_en, input, 1: enables periodic scan of all channels.
REQ-009 SHALL have port fire_measure, output, 1: one-cycle start pulse to measurement engine.
REQ-010 SHALL have port done_measure / err_measure, input, 1 each: engine completion pulse / error flag valid with done.
REQ-011 SHALL have port data_measure, input, 32: engine result, valid with done_measure.
REQ-012 SHALL have port trig_core, input, 1: trigger from engine; echo_core, output, 1: echo to engine.
REQ-013 SHALL have port trig_out, output, N_CH; echo_in, input, N_CH: per-sensor pins.
REQ-014 SHALL have ports res_valid (1), res_ch (clog2 N_CH), res_data (32), res_err (1), outputs: result record.
REQ-015 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-016 SHALL hold a pending bit per channel: set by req[i] or auto tick, cleared when channel is granted; set wins on same-cycle set/clear.
REQ-017 SHALL run auto timer counting 0..PERIOD_CYC-1 while auto_en=1, holding at 0 when auto_en=0; on wrap, sets all pending bits.
REQ-018 SHALL use FSM states IDLE, FIRE, WAIT, STORE, GAP.
REQ-019 SHALL move IDLE->FIRE when any pending bit set, granting round-robin: first pending channel after last granted, index wrapping N_CH-1->0.
REQ-020 SHALL assert fire_measure for exactly the one FIRE cycle, then go to WAIT.
REQ-021 SHALL in WAIT go to STORE on done_measure, capturing data_measure and err_measure.
REQ-022 SHALL in WAIT, if WD_CYC cycles elapse without done, go to STORE with res_data=32'hFFFF_FFFF, res_err=1.
REQ-023 SHALL in STORE pulse res_valid one cycle with res_ch=granted channel; res_ch/res_data/res_err hold until next STORE.
REQ-024 SHALL in GAP count GAP_CYC cycles, then return to IDLE; new requests during GAP only pend.
REQ-025 SHALL route trig_out[sel]=trig_core and echo_core=echo_in[sel] in FIRE/WAIT only; all other trig_out and echo_core driven 0.
REQ-026 SHALL ignore done_measure outside WAIT.
REQ-027 SHALL give latency req->fire_measure of 2 cycles from IDLE with no other pending.

Reset
REQ-028 SHALL on reset: state IDLE, pending=0, timers 0, last granted=N_CH-1 (so channel 0 wins first), all outputs 0.
REQ-029 SHALL on reset mid-measurement abandon it with no res_valid and no further fire_measure.

Structure
REQ-030 SHALL place FSM state encodings and SIM-sized defaults (GAP 20, PERIOD 500, WD 200) in shared package sensor_pkg.
REQ-031 SHALL implement round-robin selection as sub-module rr_pick (pending, last -> grant index, any).
REQ-032 SHALL be single clock domain; echo_in synchronisation is the engine's responsibility.

Verification
REQ-033 SHALL test: req=4'b0100 only, engine done data=1234 -> fire 2 cycles later, trig_out[2] follows trig_core, res_ch=2, res_data=1234, res_err=0.
REQ-034 SHALL test: req=4'b1111 same cycle after reset -> grant order 0,1,2,3, each separated by >= GAP_CYC idle cycles.
REQ-035 SHALL test: no done for WD_CYC in WAIT -> res_valid with res_data=FFFF_FFFF, res_err=1, then GAP.
REQ-036 SHALL test: auto_en=1, PERIOD 500 -> all four channels pend every 500 cycles; re-request of ch1 while ch1 in WAIT -> ch1 measured again later.
REQ-037 SHALL test: rst_n low during WAIT on ch3 -> all outputs 0, busy=0, pending cleared, next req ch0 served first.
REQ-038 SHALL test: err_measure=1 with done, data=9 -> res_err=1, res_data=9.
